// File: rtl/arki_mem_pkg.sv
// rtl/arki_mem_pkg.sv - shared types and constants for the LEGv8 memory-stage load/store unit
package arki_mem_pkg;

    localparam int          ALIGN_BITS      = 3;
    localparam int unsigned TIMEOUT_DEFAULT = 15;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        FAULT
    } mem_state_e;

    typedef enum logic [1:0] {
        FC_NONE        = 2'd0,
        FC_MISALIGN    = 2'd1,
        FC_TIMEOUT     = 2'd2,
        FC_RW_CONFLICT = 2'd3
    } fault_code_e;

    function automatic logic is_misaligned(input logic [63:0] addr);
        return addr[ALIGN_BITS-1:0] != '0;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - 8-bit access watchdog; expired fires in the cycle whose increment reaches TIMEOUT
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Aborting on the edge that would make the count TIMEOUT bounds REQ+WAIT to TIMEOUT cycles.
    assign expired = en && !clr && (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage load/store unit driving a req/gnt/rvalid data-memory port
module mem_access_unit
    import arki_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_M,
    input  logic        memRead_M,
    input  logic        memWrite_M,
    input  logic [63:0] aluResult_M,
    input  logic [63:0] writeData_M,
    output logic        stall_M,
    output logic        done_M,
    output logic [63:0] readData_M,
    output logic        fault_M,
    output logic [1:0]  faultCode_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [63:0] dmem_rdata
);

    mem_state_e  state_d, state_q;
    fault_code_e code_d, code_q;
    logic [63:0] addr_d, addr_q;
    logic [63:0] wdata_d, wdata_q;
    logic [63:0] rdata_d, rdata_q;
    logic        we_d, we_q;
    logic        ctr_clr, ctr_en, ctr_expired;
    logic        access;

    assign access = valid_M && (memRead_M || memWrite_M);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst_n   (reset_n),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .expired (ctr_expired)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        ctr_clr = 1'b0;
        ctr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    addr_d  = aluResult_M;
                    wdata_d = writeData_M;
                    we_d    = memWrite_M;
                    if (is_misaligned(aluResult_M)) begin
                        state_d = FAULT;
                        code_d  = FC_MISALIGN;
                    end else if (memRead_M && memWrite_M) begin
                        state_d = FAULT;
                        code_d  = FC_RW_CONFLICT;
                    end else begin
                        state_d = REQ;
                        ctr_clr = 1'b1;
                    end
                end
            end
            REQ: begin
                ctr_en = 1'b1;
                // A grant in the expiry cycle loses: the access is aborted regardless.
                if (ctr_expired) begin
                    state_d = FAULT;
                    code_d  = FC_TIMEOUT;
                end else if (dmem_gnt) begin
                    state_d = we_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                ctr_en = 1'b1;
                if (ctr_expired) begin
                    state_d = FAULT;
                    code_d  = FC_TIMEOUT;
                end else if (dmem_rvalid) begin
                    rdata_d = dmem_rdata;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            code_q  <= FC_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    assign dmem_req    = (state_q == REQ);
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign done_M      = (state_q == DONE);
    assign fault_M     = (state_q == FAULT);
    assign faultCode_M = fault_M ? code_q : FC_NONE;
    assign readData_M  = rdata_q;

    // Gated by reset_n so the pipeline is released the instant reset lands, even with EX/MEM live.
    assign stall_M = reset_n && (((state_q == IDLE) && access) || (state_q == REQ) || (state_q == WAIT));

endmodule
